perf_trigger_ctrl: RTL and testbench

Memory-mapped measurement controller that sits directly upstream of the cycle counter in the RISC-V performance-measurement path. It decodes processor stores to a dedicated trigger address into start/stop/abort commands and drives the 32-bit `trigger` word that the counter consumes (1 = count, 2 = stopped, 0 = idle). It also provides a watchdog auto-stop, a completed-window tally and a readable status word. Software uses it to bracket context-switch and cache-switch code regions.

---
 rtl/perf_pkg.sv | 18 +
 rtl/perf_watchdog.sv | 37 +++
 rtl/perf_trigger_ctrl.sv | 93 +++++++++
 tb/tb_perf_trigger_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared encodings for the performance-measurement trigger path.
package perf_pkg;

    typedef logic [1:0] perf_state_t;

    localparam perf_state_t ST_IDLE     = 2'd0;
    localparam perf_state_t ST_COUNTING = 2'd1;
    localparam perf_state_t ST_STOPPED  = 2'd2;

    localparam logic [31:0] CMD_ABORT = 32'd0;
    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_STOP  = 32'd2;
    localparam logic [31:0] CMD_CLEAR = 32'd3;

    localparam logic [31:0] DEF_TRIGGER_ADDR = 32'h0000_0FF0;
    localparam logic [31:0] DEF_STATUS_ADDR  = 32'h0000_0FF4;

endpackage

// File: rtl/perf_watchdog.sv
// Counts cycles spent in a measurement window and flags the last allowed one.
module perf_watchdog #(
    parameter logic [31:0] LIMIT = 32'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam logic [31:0] LAST = LIMIT - 32'd1;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the controller leaves COUNTING on the very edge that ends cycle LIMIT.
    assign expire = enable && (LIMIT != 32'd0) && (cnt_q == LAST);

endmodule

// File: rtl/perf_trigger_ctrl.sv
// Store-decoded start/stop/abort controller driving the cycle counter trigger word.
module perf_trigger_ctrl
    import perf_pkg::*;
#(
    parameter logic [31:0] TRIGGER_ADDR   = DEF_TRIGGER_ADDR,
    parameter logic [31:0] STATUS_ADDR    = DEF_STATUS_ADDR,
    parameter logic [31:0] WATCHDOG_LIMIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] trigger,
    output logic [15:0] window_count,
    output logic        timeout
);

    perf_state_t state_q, state_d;
    logic [15:0] window_count_q, window_count_d;
    logic        timeout_q, timeout_d;
    logic        cmd_hit;
    logic        wd_expire;
    logic        wd_restart;
    logic        window_end;

    assign cmd_hit = mem_write && (address == TRIGGER_ADDR);

    always_comb begin
        state_d        = state_q;
        timeout_d      = timeout_q;
        window_count_d = window_count_q;
        window_end     = 1'b0;
        // ABORT outranks both a coincident watchdog expiry and everything else.
        if (cmd_hit && writedata == CMD_ABORT) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b0;
        end else begin
            if (cmd_hit && writedata == CMD_CLEAR) begin
                window_count_d = '0;
            end
            if (cmd_hit && writedata == CMD_START && state_q != ST_COUNTING) begin
                state_d = ST_COUNTING;
            end
            if (state_q == ST_COUNTING &&
                ((cmd_hit && writedata == CMD_STOP) || wd_expire)) begin
                state_d    = ST_STOPPED;
                window_end = 1'b1;
                if (wd_expire) begin
                    timeout_d = 1'b1;
                end
            end
            if (window_end && window_count_d != 16'hFFFF) begin
                window_count_d = window_count_d + 16'd1;
            end
        end
    end

    assign wd_restart = (state_d == ST_COUNTING) && (state_q != ST_COUNTING);

    perf_watchdog #(
        .LIMIT(WATCHDOG_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_COUNTING),
        .restart(wd_restart),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            window_count_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            window_count_q <= window_count_d;
            timeout_q      <= timeout_d;
        end
    end

    assign trigger      = {30'd0, state_q};
    assign window_count = window_count_q;
    assign timeout      = timeout_q;

    // Status reflects pre-edge state even when a command store lands in the same cycle.
    assign readdata = (mem_read && address == STATUS_ADDR) ?
                      {window_count_q, 13'd0, timeout_q, state_q} : 32'd0;

endmodule

// File: tb/tb_perf_trigger_ctrl.sv
// Bench driving three controllers (watchdog off, 5, 4) from one stimulus stream.
module tb_perf_trigger_ctrl;

    localparam logic [31:0] TA = 32'h0000_0FF0;
    localparam logic [31:0] SA = 32'h0000_0FF4;
    localparam logic [31:0] XA = 32'h0000_0FF8;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] rd_o   [3];
    logic [31:0] trig_o [3];
    logic [15:0] wc_o   [3];
    logic        to_o   [3];

    int n_tests;
    int n_fail;

    // Reference model: state as 0 idle / 1 counting / 2 stopped, window length so far.
    int          lim   [3];
    int          m_st  [3];
    int          m_wc  [3];
    bit          m_to  [3];
    int          m_run [3];
    int          ccnt  [3];

    perf_trigger_ctrl #(.WATCHDOG_LIMIT(32'd0)) dut_0 (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .writedata(writedata), .readdata(rd_o[0]),
        .trigger(trig_o[0]), .window_count(wc_o[0]), .timeout(to_o[0]));

    perf_trigger_ctrl #(.WATCHDOG_LIMIT(32'd5)) dut_5 (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .writedata(writedata), .readdata(rd_o[1]),
        .trigger(trig_o[1]), .window_count(wc_o[1]), .timeout(to_o[1]));

    perf_trigger_ctrl #(.WATCHDOG_LIMIT(32'd4)) dut_4 (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .writedata(writedata), .readdata(rd_o[2]),
        .trigger(trig_o[2]), .window_count(wc_o[2]), .timeout(to_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]  = 0;
            m_wc[i]  = 0;
            m_to[i]  = 1'b0;
            m_run[i] = 0;
        end
    endtask

    function automatic logic [31:0] model_status(input int i);
        logic [15:0] w;
        logic [1:0]  s;
        w = m_wc[i][15:0];
        s = m_st[i][1:0];
        return {w, 13'd0, m_to[i], s};
    endfunction

    // Applies the command rules for the inputs present at this edge.
    task automatic model_edge();
        bit cmd;
        bit expired;
        bit stopping;
        int ns;
        cmd = mem_write && (address == TA);
        for (int i = 0; i < 3; i++) begin
            ns = m_st[i];
            expired = (m_st[i] == 1) && (lim[i] != 0) && (m_run[i] + 1 == lim[i]);
            if (cmd && writedata == 32'd0) begin
                ns = 0;
                m_to[i] = 1'b0;
            end else begin
                if (cmd && writedata == 32'd3) m_wc[i] = 0;
                if (cmd && writedata == 32'd1 && m_st[i] != 1) ns = 1;
                stopping = (m_st[i] == 1) && ((cmd && writedata == 32'd2) || expired);
                if (stopping) begin
                    ns = 2;
                    if (m_wc[i] < 65535) m_wc[i]++;
                    if (expired) m_to[i] = 1'b1;
                end
            end
            if (ns == 1 && m_st[i] == 1) m_run[i]++;
            else m_run[i] = 0;
            m_st[i] = ns;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.trig%0d", tag, i), trig_o[i], m_st[i]);
            check($sformatf("%s.wc%0d", tag, i), {16'd0, wc_o[i]}, m_wc[i]);
            check($sformatf("%s.to%0d", tag, i), {31'd0, to_o[i]}, {31'd0, m_to[i]});
        end
    endtask

    // One cycle: drive at the falling edge, check readdata pre-edge, check state after the edge.
    task automatic step(input string tag, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
        mem_write = w;
        mem_read  = r;
        address   = a;
        writedata = d;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.rd%0d", tag, i), rd_o[i],
                  (r && a == SA) ? model_status(i) : 32'd0);
            if (trig_o[i] == 32'd1) ccnt[i]++;
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    int unsigned rsel, rdat;
    logic [31:0] ra, rdv;
    bit          rw, rr;
    int          wc_before;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        lim[0] = 0; lim[1] = 5; lim[2] = 4;
        for (int i = 0; i < 3; i++) ccnt[i] = 0;
        reset = 1'b1;
        mem_write = 1'b0; mem_read = 1'b0; address = 32'd0; writedata = 32'd0;
        model_reset();
        #3;
        for (int i = 0; i < 3; i++) check($sformatf("rst.rd%0d", i), rd_o[i], 32'd0);
        check_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic window: START then STOP ten cycles later.
        idle("pre", 9);
        for (int i = 0; i < 3; i++) ccnt[i] = 0;
        step("start1", 1'b1, 1'b0, TA, 32'd1);
        idle("run1", 9);
        step("stop1", 1'b1, 1'b0, TA, 32'd2);
        check("win1.count", ccnt[0], 32'd10);
        check("win1.trig", trig_o[0], 32'd2);
        mem_read = 1'b1; address = SA; #1;
        check("win1.status", rd_o[0], 32'h0001_0002);
        step("rd1", 1'b0, 1'b1, SA, 32'd0);
        step("abort1", 1'b1, 1'b0, TA, 32'd0);

        // Watchdog auto-stop with no STOP issued.
        for (int i = 0; i < 3; i++) ccnt[i] = 0;
        step("start2", 1'b1, 1'b0, TA, 32'd1);
        idle("wd", 8);
        check("wd5.count", ccnt[1], 32'd5);
        check("wd4.count", ccnt[2], 32'd4);
        check("wd5.trig", trig_o[1], 32'd2);
        check("wd5.to", {31'd0, to_o[1]}, 32'd1);
        step("abort2", 1'b1, 1'b0, TA, 32'd0);
        check("wd5.to_clr", {31'd0, to_o[1]}, 32'd0);
        check("wd5.trig_idle", trig_o[1], 32'd0);

        // Commands that must not change anything.
        step("start3", 1'b1, 1'b0, TA, 32'd1);
        step("start3b", 1'b1, 1'b0, TA, 32'd1);
        check("ign.start_cnt", trig_o[0], 32'd1);
        step("abort3", 1'b1, 1'b0, TA, 32'd0);
        step("stop_idle", 1'b1, 1'b0, TA, 32'd2);
        step("code7", 1'b1, 1'b0, TA, 32'd7);
        step("badaddr", 1'b1, 1'b0, XA, 32'd1);
        check("ign.idle", trig_o[0], 32'd0);

        // Saturation of the window tally, then CLEAR.
        @(negedge clk);
        force dut_0.window_count_q = 16'hFFFE;
        #1;
        release dut_0.window_count_q;
        m_wc[0] = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            step("sat.start", 1'b1, 1'b0, TA, 32'd1);
            step("sat.stop", 1'b1, 1'b0, TA, 32'd2);
        end
        check("sat.wc", {16'd0, wc_o[0]}, 32'h0000_FFFF);
        step("clear", 1'b1, 1'b0, TA, 32'd3);
        check("clear.wc", {16'd0, wc_o[0]}, 32'd0);
        check("clear.trig", trig_o[0], 32'd2);

        // STOP and ABORT landing on the watchdog expiry cycle (LIMIT 4).
        step("abort4", 1'b1, 1'b0, TA, 32'd0);
        wc_before = int'(wc_o[2]);
        step("start4", 1'b1, 1'b0, TA, 32'd1);
        idle("run4", 3);
        step("stop_exp", 1'b1, 1'b0, TA, 32'd2);
        check("coinc.wc", {16'd0, wc_o[2]}, wc_before + 1);
        check("coinc.to", {31'd0, to_o[2]}, 32'd1);
        step("abort5", 1'b1, 1'b0, TA, 32'd0);
        wc_before = int'(wc_o[2]);
        step("start5", 1'b1, 1'b0, TA, 32'd1);
        idle("run5", 3);
        step("abort_exp", 1'b1, 1'b0, TA, 32'd0);
        check("coinc2.trig", trig_o[2], 32'd0);
        check("coinc2.to", {31'd0, to_o[2]}, 32'd0);
        check("coinc2.wc", {16'd0, wc_o[2]}, wc_before);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rsel = $urandom_range(0, 9);
            rw   = (rsel < 7);
            rsel = $urandom_range(0, 7);
            ra   = (rsel < 5) ? TA : ((rsel == 5) ? XA : SA);
            rdat = $urandom_range(0, 15);
            if (rdat == 0)       rdv = 32'd0;
            else if (rdat < 7)   rdv = 32'd1;
            else if (rdat < 13)  rdv = 32'd2;
            else if (rdat == 13) rdv = 32'd3;
            else if (rdat == 14) rdv = 32'd7;
            else                 rdv = $urandom;
            rr = ($urandom_range(0, 1) == 1);
            step("rand", rw, rr, ra, rdv);
        end

        // Asynchronous reset in the middle of a window.
        step("abort6", 1'b1, 1'b0, TA, 32'd0);
        step("start6", 1'b1, 1'b0, TA, 32'd1);
        idle("run6", 2);
        mem_write = 1'b0; mem_read = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst.trig", trig_o[0], 32'd0);
        check("arst.wc", {16'd0, wc_o[0]}, 32'd0);
        check_outputs("arst");
        check("arst.rd", rd_o[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post", 1'b1, 1'b0, TA, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
